// File: rtl/apb_reg_pkg.sv
// Shared constants and types for the APB register completer: address map, register indices, FSM states.
// Purely declarative; no latency or flow-control behaviour of its own.
package apb_reg_pkg;

    localparam int WS_W = 4;

    localparam logic [31:0] ADDR_NUMBER  = 32'h0000_0000;
    localparam logic [31:0] ADDR_DATE    = 32'h0000_0004;
    localparam logic [31:0] ADDR_SURNAME = 32'h0000_0008;
    localparam logic [31:0] ADDR_NAME    = 32'h0000_000C;
    localparam logic [31:0] ADDR_WRCNT   = 32'h0000_0010;

    typedef enum logic [2:0] {
        IDX_NUMBER  = 3'd0,
        IDX_DATE    = 3'd1,
        IDX_SURNAME = 3'd2,
        IDX_NAME    = 3'd3,
        IDX_WRCNT   = 3'd4
    } reg_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_DONE
    } state_e;

    function automatic logic decode_err(input logic [31:0] addr, input logic wr);
        return (addr[1:0] != 2'b00) || (addr > ADDR_WRCNT) || (wr && (addr == ADDR_WRCNT));
    endfunction

    // Unmapped addresses fold to NUMBER; decode_err masks them before use.
    function automatic reg_idx_e addr_idx(input logic [31:0] addr);
        case (addr)
            ADDR_DATE:    return IDX_DATE;
            ADDR_SURNAME: return IDX_SURNAME;
            ADDR_NAME:    return IDX_NAME;
            ADDR_WRCNT:   return IDX_WRCNT;
            ADDR_NUMBER:  return IDX_NUMBER;
            default:      return IDX_NUMBER;
        endcase
    endfunction

endpackage

// File: rtl/apb_wait_cnt.sv
// Loadable down-counter with zero flag that paces APB wait states.
// Load wins over decrement; saturates at zero so a stray decrement is harmless.
module apb_wait_cnt
    import apb_reg_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [WS_W-1:0] load_val,
    input  logic            dec,
    output logic            zero
);

    logic [WS_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_reg_completer.sv
// APB completer with four RW registers and a write counter; PREADY after WAIT_STATES low access cycles.
// Outputs registered; transfers abort when PSEL drops, and a new setup phase mid-wait restarts the transfer.
module apb_reg_completer #(
    parameter int WAIT_STATES = 1
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR
);
    import apb_reg_pkg::*;

    // Counter holds wait cycles remaining after the first access cycle (spent in SETUP).
    localparam logic [WS_W-1:0] WS_LOAD   = (WAIT_STATES == 0) ? '0 : WS_W'(WAIT_STATES - 1);
    localparam logic            ZERO_WAIT = (WAIT_STATES == 0);

    state_e      state_q, state_d;
    reg_idx_e    idx_q, cur_idx;
    logic        write_q, err_q, cur_write, cur_err;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic [31:0] rw_q [4];
    logic [31:0] wrcnt_q;
    logic [31:0] rd_val;
    logic        setup_phase, latch, cnt_load, cnt_dec, cnt_zero, commit;

    assign setup_phase = PSEL && !PENABLE;

    apb_wait_cnt u_wait_cnt (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .load     (cnt_load),
        .load_val (WS_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        latch    = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (setup_phase) latch = 1'b1;
            end
            ST_SETUP, ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (!PENABLE) begin
                    latch = 1'b1;
                end else if (cnt_zero) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                commit = PSEL && PENABLE && write_q && !err_q;
                if (setup_phase) latch = 1'b1;
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (latch) begin
            state_d  = ZERO_WAIT ? ST_DONE : ST_SETUP;
            cnt_load = 1'b1;
        end
    end

    // A zero-wait transfer reaches DONE straight from the setup phase, so use live bus values then.
    always_comb begin
        cur_idx   = latch ? addr_idx(PADDR) : idx_q;
        cur_write = latch ? PWRITE : write_q;
        cur_err   = latch ? decode_err(PADDR, PWRITE) : err_q;
        rd_val    = '0;
        case (cur_idx)
            IDX_NUMBER:  rd_val = rw_q[0];
            IDX_DATE:    rd_val = rw_q[1];
            IDX_SURNAME: rd_val = rw_q[2];
            IDX_NAME:    rd_val = rw_q[3];
            IDX_WRCNT:   rd_val = wrcnt_q;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_NUMBER;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            wrcnt_q <= '0;
            for (int i = 0; i < 4; i++) rw_q[i] <= '0;
            PRDATA  <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                idx_q   <= cur_idx;
                write_q <= cur_write;
                err_q   <= cur_err;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
            if (commit) begin
                wrcnt_q <= wrcnt_q + 32'd1;
                for (int b = 0; b < 4; b++) begin
                    if (strb_q[b]) rw_q[idx_q[1:0]][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
            PREADY  <= (state_d == ST_DONE);
            PSLVERR <= (state_d == ST_DONE) && cur_err;
            PRDATA  <= ((state_d == ST_DONE) && !cur_write && !cur_err) ? rd_val : '0;
        end
    end

endmodule

// File: tb/tb_apb_reg_completer.sv
// Scoreboard bench: three completers with WAIT_STATES 0, 2 and 3 driven by directed APB transfers.
module tb_apb_reg_completer;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    logic        clk;
    logic        rst_n   [3];
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [3:0]  pstrb   [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    exp_t sb[$];
    int   cmp_cnt = 0;
    int   mm_cnt  = 0;
    int   waits [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_reg_completer #(.WAIT_STATES(g == 0 ? 0 : g + 1)) u_dut (
            .PCLK    (clk),
            .PRESETn (rst_n[g]),
            .PSEL    (psel[g]),
            .PENABLE (penable[g]),
            .PWRITE  (pwrite[g]),
            .PADDR   (paddr[g]),
            .PWDATA  (pwdata[g]),
            .PSTRB   (pstrb[g]),
            .PRDATA  (prdata[g]),
            .PREADY  (pready[g]),
            .PSLVERR (pslverr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            mm_cnt++;
            $display("FAIL %s dut%0d: got 0x%08h, required 0x%08h", nm, d, act, req);
        end
    endtask

    task automatic setup_phase(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    endtask

    task automatic push_exp(input int d, input logic [31:0] erd, input logic eerr);
        exp_t e;
        e.d = d; e.rdata = erd; e.err = eerr; e.waits = (d == 0) ? 0 : d + 1;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pready[d] && n < 40);
        if (!pready[d]) begin
            cmp_cnt++;
            mm_cnt++;
            $display("FAIL ready_timeout dut%0d: PREADY=0 after %0d cycles, required 1", d, n);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] erd, input logic eerr);
        push_exp(d, erd, eerr);
        @(posedge clk); #1;
        setup_phase(d, wr, a, wd, st);
        @(posedge clk); #1;
        penable[d] = 1'b1;
        wait_ready(d);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic eerr);
        xfer(d, 1'b1, a, wd, st, 32'h0, eerr);
    endtask

    task automatic rd(input int d, input logic [31:0] a, input logic [31:0] erd, input logic eerr);
        xfer(d, 1'b0, a, 32'h0, 4'h0, erd, eerr);
    endtask

    task automatic chk_outputs_zero(input string nm, input int d);
        chk({nm, "_pready"},  d, {31'h0, pready[d]},  32'h0);
        chk({nm, "_prdata"},  d, prdata[d],           32'h0);
        chk({nm, "_pslverr"}, d, {31'h0, pslverr[d]}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = '0; pwdata[i] = '0; pstrb[i] = '0; waits[i] = 0;
        end

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    for (int d = 0; d < 3; d++) begin
                        if (rst_n[d]) begin
                            if (psel[d] && !penable[d]) waits[d] = 0;
                            if (pready[d]) begin
                                if (sb.size() == 0 || sb[0].d != d) begin
                                    cmp_cnt++;
                                    mm_cnt++;
                                    $display("FAIL unexpected_pready dut%0d: PREADY=1, required 0", d);
                                end else begin
                                    e = sb.pop_front();
                                    chk("prdata",  d, prdata[d],            e.rdata);
                                    chk("pslverr", d, {31'h0, pslverr[d]},  {31'h0, e.err});
                                    chk("waits",   d, waits[d],             e.waits);
                                end
                                waits[d] = 0;
                            end else begin
                                if (psel[d] && penable[d]) waits[d]++;
                                chk("idle_prdata",  d, prdata[d],           32'h0);
                                chk("idle_pslverr", d, {31'h0, pslverr[d]}, 32'h0);
                            end
                        end
                    end
                end
            end
        join_none

        #2;
        for (int i = 0; i < 3; i++) chk_outputs_zero("reset", i);
        #10;
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // Zero-wait completer: basic access, decode errors, strobes, write counter.
        wr(0, 32'h00, 32'd23,        4'hF, 1'b0);
        rd(0, 32'h00, 32'h0000_0017, 1'b0);
        wr(0, 32'h04, 32'h1111_1111, 4'hF, 1'b0);
        wr(0, 32'h08, 32'h98A0_A1A0, 4'hF, 1'b0);
        wr(0, 32'h0C, 32'h0000_ABCD, 4'hF, 1'b0);
        wr(0, 32'h14, 32'hDEAD_BEEF, 4'hF, 1'b1);
        wr(0, 32'h06, 32'hDEAD_BEEF, 4'hF, 1'b1);
        wr(0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
        rd(0, 32'h03, 32'h0,         1'b1);
        rd(0, 32'h04, 32'h1111_1111, 1'b0);
        rd(0, 32'h00, 32'h0000_0017, 1'b0);
        rd(0, 32'h10, 32'h0000_0004, 1'b0);
        wr(0, 32'h08, 32'hFFFF_FFFF, 4'b0011, 1'b0);
        rd(0, 32'h08, 32'h98A0_FFFF, 1'b0);
        wr(0, 32'h0C, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        rd(0, 32'h0C, 32'h0000_ABCD, 1'b0);
        rd(0, 32'h10, 32'h0000_0006, 1'b0);

        // Two wait states: timing, restart on a mid-wait setup phase, abort on PSEL drop.
        wr(1, 32'h04, 32'h2012_2023, 4'hF, 1'b0);
        rd(1, 32'h04, 32'h2012_2023, 1'b0);

        push_exp(1, 32'h0, 1'b0);
        @(posedge clk); #1;
        setup_phase(1, 1'b1, 32'h08, 32'h0000_AAAA, 4'hF);
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        setup_phase(1, 1'b1, 32'h0C, 32'h0000_5555, 4'hF);
        @(posedge clk); #1;
        penable[1] = 1'b1;
        wait_ready(1);
        rd(1, 32'h08, 32'h0,         1'b0);
        rd(1, 32'h0C, 32'h0000_5555, 1'b0);

        @(posedge clk); #1;
        setup_phase(1, 1'b1, 32'h00, 32'hCAFE_F00D, 4'hF);
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (4) @(posedge clk);
        rd(1, 32'h00, 32'h0,         1'b0);
        rd(1, 32'h10, 32'h0000_0002, 1'b0);

        // Three wait states: reset during a read's completion cycle, then during a write's wait.
        wr(2, 32'h0C, 32'h1234_5678, 4'hF, 1'b0);
        @(posedge clk); #1;
        setup_phase(2, 1'b0, 32'h0C, 32'h0, 4'h0);
        @(posedge clk); #1;
        penable[2] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("done_pready", 2, {31'h0, pready[2]}, 32'h1);
        chk("done_prdata", 2, prdata[2],          32'h1234_5678);
        rst_n[2] = 1'b0;
        #1;
        chk_outputs_zero("rst_in_done", 2);
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        rst_n[2] = 1'b1;

        @(posedge clk); #1;
        setup_phase(2, 1'b1, 32'h0C, 32'h85AA_A0E2, 4'hF);
        @(posedge clk); #1;
        penable[2] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        #1;
        chk_outputs_zero("rst_in_wait", 2);
        @(posedge clk); #1;
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        rd(2, 32'h0C, 32'h0, 1'b0);
        rd(2, 32'h10, 32'h0, 1'b0);

        repeat (5) @(posedge clk);
        chk("sb_drained", 0, sb.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mm_cnt);
        $finish;
    end

endmodule

// File: doc/apb_reg_completer.md
APB_REG_COMPLETER -- requirements
Module: apb_reg_completer

Interface
REQ-001 Parameter WAIT_STATES, default 1, access-phase cycles with PREADY low before completion (0..15).
REQ-002 PCLK  input  1  sole clock; all state changes on rising edge.
REQ-003 PRESETn  input  1  asynchronous, active-low reset.
REQ-004 PSEL  input  1  completer select from master.
REQ-005 PENABLE  input  1  access-phase indicator from master.
REQ-006 PWRITE  input  1  1 = write, 0 = read.
REQ-007 PADDR  input  32  byte address.
REQ-008 PWDATA  input  32  write data.
REQ-009 PSTRB  input  4  byte-lane write enables; bit n covers PWDATA[8n+7:8n].
REQ-010 PRDATA  output  32  read data, valid only while PREADY is high.
REQ-011 PREADY  output  1  transfer-complete indicator.
REQ-012 PSLVERR  output  1  transfer error, valid only while PREADY is high.

Function
REQ-013 Register map: 0x00 NUMBER (RW), 0x04 DATE (RW), 0x08 SURNAME (RW), 0x0C NAME (RW), 0x10 WRCNT (RO, count of successful writes).
REQ-014 Decode error: PADDR[1:0] != 0, PADDR > 0x10, or write to 0x10.
REQ-015 FSM states: IDLE, SETUP, WAIT, DONE.
REQ-016 IDLE -> SETUP when PSEL=1 and PENABLE=0; latch PADDR, PWRITE, PWDATA, PSTRB; load wait counter with WAIT_STATES.
REQ-017 SETUP -> WAIT when counter > 0, else -> DONE; counter decrements once per WAIT cycle; WAIT -> DONE when counter reaches 0.
REQ-018 PREADY is registered and high only in DONE; WAIT_STATES=0 gives zero-wait completion (PREADY high in first access cycle).
REQ-019 DONE lasts exactly one cycle; DONE -> SETUP if PSEL=1 and PENABLE=0 that cycle (back-to-back), else -> IDLE.
REQ-020 Write commits at the edge ending DONE when PSEL=PENABLE=1 and no error; only lanes with PSTRB=1 update.
REQ-021 WRCNT increments by 1 per committed write, wrapping 0xFFFFFFFF -> 0; PSTRB=0000 write still counts.
REQ-022 Read: PRDATA = addressed register in DONE; PRDATA = 0 outside DONE and on errored reads.
REQ-023 PSLVERR = 1 in DONE for decode errors, else 0; errored writes modify no register and do not count.
REQ-024 PSEL dropping in SETUP or WAIT aborts: -> IDLE, no commit, PREADY stays low.
REQ-025 PENABLE=0 with PSEL=1 during WAIT is a protocol violation: treated as new setup (relatch, restart counter).
REQ-026 Address/control changes during WAIT are ignored; latched values are used.

Reset
REQ-027 PRESETn low forces FSM to IDLE, counter 0, NUMBER/DATE/SURNAME/NAME/WRCNT 0, PRDATA 0, PREADY 0, PSLVERR 0, immediately and independent of PCLK.
REQ-028 Reset asserted mid-transfer discards the transfer with no commit; first transfer after release starts from IDLE.

Structure
REQ-029 Package apb_reg_pkg holds address constants, register-index enum, FSM state enum, and the WAIT_STATES width constant.
REQ-030 One sub-module, apb_wait_cnt: loadable down-counter with zero flag, used for wait-state timing.
REQ-031 Register storage, decode, and the FSM live in apb_reg_completer.

Verification
REQ-032 WAIT_STATES=0: write 23 to 0x00, then read 0x00 -> PRDATA=0x00000017, PREADY high in first access cycle, PSLVERR=0.
REQ-033 WAIT_STATES=2: write 0x20122023 to 0x04 -> PREADY low for 2 access cycles, high on 3rd; read 0x04 -> 0x20122023.
REQ-034 SURNAME=0x98A0A1A0, write 0xFFFFFFFF to 0x08 with PSTRB=0011 -> read 0x08 returns 0x98A0FFFF.
REQ-035 Write to 0x14, 0x06, and 0x10 -> PSLVERR=1 with PREADY each time, all registers unchanged; after 4 good writes, read 0x10 -> 0x00000004.
REQ-036 WAIT_STATES=3: assert PRESETn low during WAIT of a write of 0x85AAA0E2 to 0x0C -> outputs 0 immediately; read 0x0C after release -> 0.
REQ-037 Drop PSEL during WAIT of a write to 0x00 -> no PREADY pulse, NUMBER unchanged, WRCNT unchanged.
